// File: rtl/fifo_sync_ctrl_if.sv
// Handshake and memory-control bundle for the single-clock FIFO controller.
// The controller takes the slave view; the requesting logic takes the master view.
interface fifo_sync_ctrl_if #(
    parameter int DEPTH = 8
);
    localparam int ADDR_W = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              i_flush;
    logic              i_clr_err;
    logic              i_wr;
    logic              i_rd;
    logic              o_wr_en;
    logic [ADDR_W-1:0] o_wr_addr;
    logic              o_rd_en;
    logic [ADDR_W-1:0] o_rd_addr;
    logic              o_full;
    logic              o_empty;
    logic              o_afull;
    logic              o_aempty;
    logic [CNT_W-1:0]  o_count;
    logic              o_ovf;
    logic              o_udf;

    modport master (
        output i_flush, i_clr_err, i_wr, i_rd,
        input  o_wr_en, o_wr_addr, o_rd_en, o_rd_addr,
        input  o_full, o_empty, o_afull, o_aempty, o_count, o_ovf, o_udf
    );

    modport slave (
        input  i_flush, i_clr_err, i_wr, i_rd,
        output o_wr_en, o_wr_addr, o_rd_en, o_rd_addr,
        output o_full, o_empty, o_afull, o_aempty, o_count, o_ovf, o_udf
    );
endinterface

// File: rtl/fifo_sync_ctrl.sv
// Single-clock FIFO pointer/flag/occupancy controller for an external dual-port RAM.
// Supports non-power-of-2 depth, programmable almost flags, flush and sticky errors.
module fifo_sync_ctrl #(
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    fifo_sync_ctrl_if.slave bus
);
    localparam int ADDR_W = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  AF_CNT   = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0]  AE_CNT   = CNT_W'(AE_LEVEL);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              ovf;
    logic              udf;

    logic full;
    logic empty;
    logic push_ok;
    logic pop_ok;
    logic ovf_set;
    logic udf_set;

    // Wrap explicitly at DEPTH-1 so non-power-of-2 depths never address past the RAM.
    function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + ADDR_W'(1);
    endfunction

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    assign push_ok = bus.i_wr & ~full  & ~bus.i_flush & ~i_rst;
    assign pop_ok  = bus.i_rd & ~empty & ~bus.i_flush & ~i_rst;
    assign ovf_set = bus.i_wr & full  & ~bus.i_flush;
    assign udf_set = bus.i_rd & empty & ~bus.i_flush;

    always_ff @(posedge i_clk) begin
        if (i_rst || bus.i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= next_ptr(wr_ptr);
            if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Error flags survive flush; a set in the same cycle as a clear wins.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (ovf_set)            ovf <= 1'b1;
            else if (bus.i_clr_err) ovf <= 1'b0;
            if (udf_set)            udf <= 1'b1;
            else if (bus.i_clr_err) udf <= 1'b0;
        end
    end

    assign bus.o_wr_en   = push_ok;
    assign bus.o_wr_addr = wr_ptr;
    assign bus.o_rd_en   = pop_ok;
    assign bus.o_rd_addr = rd_ptr;
    assign bus.o_full    = full;
    assign bus.o_empty   = empty;
    assign bus.o_afull   = (count >= AF_CNT);
    assign bus.o_aempty  = (count <= AE_CNT);
    assign bus.o_count   = count;
    assign bus.o_ovf     = ovf;
    assign bus.o_udf     = udf;
endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// Scenario bench for fifo_sync_ctrl at DEPTH=5 with a reference model and address scoreboards.
module tb_fifo_sync_ctrl;
    localparam int DEPTH  = 5;
    localparam int ADDR_W = 3;
    localparam int CNT_W  = 3;

    logic i_clk = 1'b0;
    logic i_rst;
    always #5 i_clk = ~i_clk;

    fifo_sync_ctrl_if #(.DEPTH(DEPTH)) bus ();

    fifo_sync_ctrl #(.DEPTH(DEPTH)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    int exp_wa[$];
    int exp_ra[$];

    // Reference model state
    int m_wp, m_rp, m_cnt;
    bit m_ovf, m_udf;
    bit c_wr, c_rd, c_fl, c_clr, c_rst;
    bit exp_we, exp_re;

    // Drive one cycle of inputs and queue the addresses the model expects to be used.
    task automatic apply(input bit wr, input bit rd, input bit fl, input bit clr, input bit rs);
        c_wr = wr; c_rd = rd; c_fl = fl; c_clr = clr; c_rst = rs;
        bus.i_wr = wr; bus.i_rd = rd; bus.i_flush = fl; bus.i_clr_err = clr; i_rst = rs;
        exp_we = wr && (m_cnt < DEPTH) && !fl && !rs;
        exp_re = rd && (m_cnt > 0) && !fl && !rs;
        if (exp_we) exp_wa.push_back(m_wp);
        if (exp_re) exp_ra.push_back(m_rp);
        #1;
    endtask

    task automatic tick();
        bit pu, po;
        @(posedge i_clk);
        if (c_rst) begin
            m_wp = 0; m_rp = 0; m_cnt = 0; m_ovf = 0; m_udf = 0;
        end else begin
            pu = exp_we; po = exp_re;
            if (c_wr && m_cnt == DEPTH && !c_fl) m_ovf = 1;
            else if (c_clr) m_ovf = 0;
            if (c_rd && m_cnt == 0 && !c_fl) m_udf = 1;
            else if (c_clr) m_udf = 0;
            if (c_fl) begin
                m_wp = 0; m_rp = 0; m_cnt = 0;
            end else begin
                if (pu) m_wp = (m_wp + 1) % DEPTH;
                if (po) m_rp = (m_rp + 1) % DEPTH;
                m_cnt = m_cnt + int'(pu) - int'(po);
            end
        end
        #1;
    endtask

    // Push/pop cycle with enable and scoreboard address checks, then state checks.
    task automatic run_cycle(input string tag, input bit wr, input bit rd);
        int ea;
        apply(wr, rd, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (bus.o_wr_en !== exp_we || bus.o_rd_en !== exp_re) begin
            n_bad++;
            $display("FAIL %s_en: got wr_en=%b rd_en=%b want %b %b", tag, bus.o_wr_en, bus.o_rd_en, exp_we, exp_re);
        end
        if (exp_we && bus.o_wr_en) begin
            ea = exp_wa.pop_front();
            n_vec++;
            if (bus.o_wr_addr !== ADDR_W'(ea)) begin
                n_bad++;
                $display("FAIL %s_wr_addr: got %0d want %0d", tag, bus.o_wr_addr, ea);
            end
        end
        if (exp_re && bus.o_rd_en) begin
            ea = exp_ra.pop_front();
            n_vec++;
            if (bus.o_rd_addr !== ADDR_W'(ea)) begin
                n_bad++;
                $display("FAIL %s_rd_addr: got %0d want %0d", tag, bus.o_rd_addr, ea);
            end
        end
        exp_wa.delete(); exp_ra.delete();
        tick();
        n_vec++;
        if (bus.o_count !== CNT_W'(m_cnt) || bus.o_full !== (m_cnt == DEPTH) || bus.o_empty !== (m_cnt == 0)
            || bus.o_afull !== (m_cnt >= DEPTH - 1) || bus.o_aempty !== (m_cnt <= 1)
            || bus.o_ovf !== m_ovf || bus.o_udf !== m_udf) begin
            n_bad++;
            $display("FAIL %s_state: got cnt=%0d f=%b e=%b af=%b ae=%b ovf=%b udf=%b want cnt=%0d ovf=%b udf=%b",
                     tag, bus.o_count, bus.o_full, bus.o_empty, bus.o_afull, bus.o_aempty, bus.o_ovf, bus.o_udf,
                     m_cnt, m_ovf, m_udf);
        end
    endtask

    task automatic test_reset();
        m_wp = 0; m_rp = 0; m_cnt = 0; m_ovf = 0; m_udf = 0;
        apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        n_vec++;
        if (bus.o_wr_en !== 1'b0 || bus.o_rd_en !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_en: got wr_en=%b rd_en=%b want 0 0", bus.o_wr_en, bus.o_rd_en);
        end
        tick();
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (bus.o_count !== 3'd0 || bus.o_empty !== 1'b1 || bus.o_full !== 1'b0 || bus.o_aempty !== 1'b1
            || bus.o_afull !== 1'b0 || bus.o_ovf !== 1'b0 || bus.o_udf !== 1'b0
            || bus.o_wr_addr !== 3'd0 || bus.o_rd_addr !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_state: got cnt=%0d e=%b f=%b ae=%b af=%b ovf=%b udf=%b wa=%0d ra=%0d want 0 1 0 1 0 0 0 0 0",
                     bus.o_count, bus.o_empty, bus.o_full, bus.o_aempty, bus.o_afull, bus.o_ovf, bus.o_udf,
                     bus.o_wr_addr, bus.o_rd_addr);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            run_cycle("fill", 1'b1, 1'b0);
            n_vec++;
            if (bus.o_count !== CNT_W'(i + 1) || bus.o_full !== (i == 4) || bus.o_afull !== (i >= 3) || bus.o_ovf !== 1'b0) begin
                n_bad++;
                $display("FAIL fill_step%0d: got cnt=%0d full=%b afull=%b ovf=%b want cnt=%0d full=%b afull=%b ovf=0",
                         i, bus.o_count, bus.o_full, bus.o_afull, bus.o_ovf, i + 1, i == 4, i >= 3);
            end
        end
    endtask

    task automatic test_full_no_bypass();
        apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (bus.o_wr_en !== 1'b0 || bus.o_rd_en !== 1'b1 || bus.o_rd_addr !== 3'd0) begin
            n_bad++;
            $display("FAIL full_wr_rd_en: got wr_en=%b rd_en=%b rd_addr=%0d want 0 1 0", bus.o_wr_en, bus.o_rd_en, bus.o_rd_addr);
        end
        exp_wa.delete(); exp_ra.delete();
        tick();
        n_vec++;
        if (bus.o_count !== 3'd4 || bus.o_ovf !== 1'b1) begin
            n_bad++;
            $display("FAIL full_wr_rd_state: got cnt=%0d ovf=%b want 4 1", bus.o_count, bus.o_ovf);
        end
    endtask

    task automatic test_wrap();
        run_cycle("drain", 1'b0, 1'b1);
        run_cycle("drain", 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            n_vec++;
            if (bus.o_wr_addr >= 3'd5 || bus.o_rd_addr >= 3'd5) begin
                n_bad++;
                $display("FAIL wrap_range: got wa=%0d ra=%0d want <5", bus.o_wr_addr, bus.o_rd_addr);
            end
            run_cycle("wrap", 1'b1, 1'b1);
            n_vec++;
            if (bus.o_count !== 3'd2 || bus.o_full !== 1'b0 || bus.o_empty !== 1'b0) begin
                n_bad++;
                $display("FAIL wrap_count: got cnt=%0d full=%b empty=%b want 2 0 0", bus.o_count, bus.o_full, bus.o_empty);
            end
        end
    endtask

    task automatic test_empty_no_bypass();
        apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        run_cycle("drain2", 1'b0, 1'b1);
        run_cycle("drain2", 1'b0, 1'b1);
        apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (bus.o_rd_en !== 1'b0 || bus.o_wr_en !== 1'b1) begin
            n_bad++;
            $display("FAIL empty_wr_rd_en: got rd_en=%b wr_en=%b want 0 1", bus.o_rd_en, bus.o_wr_en);
        end
        exp_wa.delete(); exp_ra.delete();
        tick();
        n_vec++;
        if (bus.o_count !== 3'd1 || bus.o_udf !== 1'b1 || bus.o_ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL empty_wr_rd_state: got cnt=%0d udf=%b ovf=%b want 1 1 0", bus.o_count, bus.o_udf, bus.o_ovf);
        end
        apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        n_vec++;
        if (bus.o_udf !== 1'b0) begin
            n_bad++;
            $display("FAIL clr_err: got udf=%b want 0", bus.o_udf);
        end
        run_cycle("drain3", 1'b0, 1'b1);
        // underflow request and clear together: the set must win
        apply(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        n_vec++;
        if (bus.o_udf !== 1'b1) begin
            n_bad++;
            $display("FAIL set_wins: got udf=%b want 1", bus.o_udf);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) run_cycle("preflush", 1'b1, 1'b0);
        apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        n_vec++;
        if (bus.o_wr_en !== 1'b0 || bus.o_rd_en !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_en: got wr_en=%b rd_en=%b want 0 0", bus.o_wr_en, bus.o_rd_en);
        end
        tick();
        n_vec++;
        if (bus.o_count !== 3'd0 || bus.o_empty !== 1'b1 || bus.o_wr_addr !== 3'd0 || bus.o_rd_addr !== 3'd0
            || bus.o_udf !== 1'b1 || bus.o_ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_state: got cnt=%0d e=%b wa=%0d ra=%0d udf=%b ovf=%b want 0 1 0 0 1 0",
                     bus.o_count, bus.o_empty, bus.o_wr_addr, bus.o_rd_addr, bus.o_udf, bus.o_ovf);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) run_cycle("prerst", 1'b1, 1'b0);
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        n_vec++;
        if (bus.o_wr_en !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_en: got wr_en=%b want 0", bus.o_wr_en);
        end
        tick();
        n_vec++;
        if (bus.o_count !== 3'd0 || bus.o_wr_addr !== 3'd0 || bus.o_rd_addr !== 3'd0 || bus.o_ovf !== 1'b0
            || bus.o_udf !== 1'b0 || bus.o_empty !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid_state: got cnt=%0d wa=%0d ra=%0d ovf=%b udf=%b e=%b want 0 0 0 0 0 1",
                     bus.o_count, bus.o_wr_addr, bus.o_rd_addr, bus.o_ovf, bus.o_udf, bus.o_empty);
        end
    endtask

    initial begin
        i_rst = 1'b1;
        bus.i_wr = 1'b0; bus.i_rd = 1'b0; bus.i_flush = 1'b0; bus.i_clr_err = 1'b0;
        @(posedge i_clk);
        #1;
        test_reset();
        test_fill();
        test_full_no_bypass();
        test_wrap();
        test_empty_no_bypass();
        test_flush();
        test_reset_mid();
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/fifo_sync_ctrl.md
Name: fifo_sync_ctrl

Overview:
Single-clock FIFO pointer, flag and occupancy controller that drives an external dual-port FIFO memory. It is the parametrised successor of the per-domain FIFO signal generator, for use where both sides share one clock. It adds:
- arbitrary (non-power-of-2) depth
- occupancy count
- programmable almost-full/almost-empty flags
- synchronous flush
- sticky overflow/underflow error flags

Parameters:
DEPTH, 8, number of FIFO entries; any integer >= 2, not required to be a power of 2.
AF_LEVEL, DEPTH-1, o_afull asserts when count >= AF_LEVEL; legal range 1..DEPTH.
AE_LEVEL, 1, o_aempty asserts when count <= AE_LEVEL; legal range 0..DEPTH-1.
ADDR_W (localparam), max(1,$clog2(DEPTH)), memory address width.
CNT_W (localparam), $clog2(DEPTH+1), occupancy width.

Ports:
i_clk  in  1  clock; all logic on rising edge.
i_rst  in  1  synchronous reset, active-high.
i_flush  in  1  synchronous flush; empties the FIFO.
i_clr_err  in  1  clears sticky error flags.
i_wr  in  1  push request.
i_rd  in  1  pop request.
o_wr_en  out  1  memory write enable (accepted push).
o_wr_addr  out  ADDR_W  memory write address.
o_rd_en  out  1  memory read enable (accepted pop).
o_rd_addr  out  ADDR_W  memory read address.
o_full  out  1  count == DEPTH.
o_empty  out  1  count == 0.
o_afull  out  1  count >= AF_LEVEL.
o_aempty  out  1  count <= AE_LEVEL.
o_count  out  CNT_W  current occupancy.
o_ovf  out  1  sticky: push requested while full.
o_udf  out  1  sticky: pop requested while empty.

Behaviour:
- State registers: wr_ptr, rd_ptr (ADDR_W), count (CNT_W), ovf, udf. All flags decode combinationally from the count register; no combinational path from i_wr/i_rd to any flag.
- Reset (i_rst=1 at a clock edge):
  - wr_ptr=rd_ptr=0, count=0, ovf=udf=0.
  - Hence o_empty=1, o_full=0, o_count=0, o_aempty=1 (AE_LEVEL>=0), o_afull=0 (AF_LEVEL>=1).
  - o_wr_en and o_rd_en are forced 0 while i_rst=1.
- Accept rules (combinational, same cycle):
  - push_ok = i_wr & ~o_full & ~i_flush & ~i_rst
  - pop_ok = i_rd & ~o_empty & ~i_flush & ~i_rst
  - o_wr_en=push_ok, o_wr_addr=wr_ptr; o_rd_en=pop_ok, o_rd_addr=rd_ptr.
- No bypass:
  - A write while full is rejected even if a pop occurs the same cycle.
  - A read while empty is rejected even if a push occurs the same cycle.
- Pointer update: on push_ok, wr_ptr <= (wr_ptr==DEPTH-1) ? 0 : wr_ptr+1. rd_ptr follows the same rule on pop_ok. Wrap is explicit at DEPTH-1, not at 2^ADDR_W.
- Count update:
  - push_ok & ~pop_ok: count+1
  - pop_ok & ~push_ok: count-1
  - both or neither: unchanged
  - count never leaves 0..DEPTH.
- Flush (i_flush=1, i_rst=0):
  - wr_ptr, rd_ptr, count <= 0.
  - Takes priority over push/pop; no memory enables that cycle.
  - ovf/udf are not affected.
- Errors:
  - ovf <= 1 on any cycle with i_wr & o_full & ~i_flush.
  - udf <= 1 on any cycle with i_rd & o_empty & ~i_flush.
  - i_clr_err=1 clears them. If set and clear occur in the same cycle, set wins.
  - Only i_rst or i_clr_err clears them.
- Read data timing: data is valid from the external memory one cycle after o_rd_en (synchronous-read RAM); the controller adds no further latency.
- Priority order: i_rst > i_flush > push/pop.

Test Plan:
- DEPTH=5: reset, then push 5 with i_wr=1, i_rd=0 -> o_wr_addr 0,1,2,3,4. o_count 1..5; o_full=1 after 5th edge; o_afull=1 from count 4; o_ovf still 0.
- From full (count=5), i_wr=1 & i_rd=1 one cycle -> o_wr_en=0, o_rd_en=1, o_rd_addr=0, count=4, o_ovf=1.
- DEPTH=5 wrap: 7 push/pop pairs interleaved at count=2 -> o_wr_addr sequence wraps 4->0 and never reaches 5..7; count stays 2; o_full/o_empty never assert.
- Empty FIFO, i_rd=1 & i_wr=1 same cycle -> o_rd_en=0, o_wr_en=1, count=1, o_udf=1. Then i_clr_err=1 with i_rd=0 -> o_udf=0 next edge.
- Count=3, i_flush=1 with i_wr=1 & i_rd=1 -> no enables; next cycle count=0, o_empty=1, o_wr_addr=o_rd_addr=0. Error flags keep their prior values.
- Mid-operation i_rst=1 at count=3 while i_wr=1 -> o_wr_en=0 that cycle. After the edge: count=0, pointers 0, o_ovf=o_udf=0, o_empty=1.
